// File: rtl/conv1_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : conv1_frame_sched
// Purpose : Reads one image frame from pixel memory into the conv1 layer and
//           counts its results. Define CONV1_SCHED_TIMEOUT_EN for a drain watchdog.
// Revision: 1.0
// ============================================================================
module conv1_frame_sched #(
  parameter  int WIDTH       = 28,
  parameter  int HEIGHT      = 28,
  parameter  int DATA_BITS   = 8,
  parameter  int KERNEL_SIZE = 5,
  parameter  int TIMEOUT     = 4096,
  localparam int NPIX        = WIDTH * HEIGHT,
  localparam int NOUT        = (WIDTH - KERNEL_SIZE + 1) * (HEIGHT - KERNEL_SIZE + 1),
  localparam int AW          = $clog2(NPIX),
  localparam int CW          = $clog2(NOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [DATA_BITS-1:0] mem_data,
  output logic [DATA_BITS-1:0] pix_out,
  output logic                 pix_valid,
  input  logic                 conv_valid,
  output logic [CW-1:0]        out_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(NOUT);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic          r_pix_valid;
  logic          w_rd_en;
  logic          w_busy;
  logic          w_done;
  logic          w_frame_start;
  logic          w_counting;
  logic          w_tmo_hit;

  assign w_frame_start = (r_state == S_IDLE) && start;
  assign w_counting    = (r_state == S_FEED) || (r_state == S_DRAIN);

`ifdef CONV1_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo;
  logic          r_err;

  // Counts cycles spent in DRAIN; cleared whenever the FSM is elsewhere.
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_DRAIN) r_tmo <= r_tmo + 1'b1;
      else                    r_tmo <= '0;
      if (w_frame_start)
        r_err <= 1'b0;
      else if ((r_state == S_DRAIN) && (r_cnt != CNT_MAX) && w_tmo_hit)
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT;
  assign w_tmo_hit        = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FEED;
      S_FEED:  if (!hold && (r_addr == LAST_ADDR)) w_next = S_DRAIN;
      S_DRAIN: begin
        if (r_cnt == CNT_MAX) w_next = S_DONE;
        else if (w_tmo_hit)   w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_busy  = 1'b0;
      S_FEED:  w_rd_en = !hold;
      S_DONE:  w_done  = 1'b1;
      default: ;
    endcase
  end

  // The address parks on the last pixel instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= w_rd_en;
      if (w_frame_start) begin
        r_addr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_rd_en && (r_addr != LAST_ADDR)) r_addr <= r_addr + 1'b1;
        if (w_counting && conv_valid && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Memory output register supplies the data; it is qualified by the delayed strobe.
  assign pix_out   = r_pix_valid ? mem_data : '0;
  assign pix_valid = r_pix_valid;
  assign mem_rd_en = w_rd_en;
  assign mem_addr  = r_addr;
  assign out_cnt   = r_cnt;
  assign busy      = w_busy;
  assign done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_conv1_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv1_frame_sched
// Purpose : Randomised frame-level bench for conv1_frame_sched.
// Revision: 1.0
// ============================================================================
module tb_conv1_frame_sched;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int DB   = 8;
  localparam int K    = 5;
  localparam int TO   = 64;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - K + 1) * (H - K + 1);
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(NOUT + 1);
  localparam int FRAME_LIMIT = 2 * NPIX + 200;

  logic          clk;
  logic          rst;
  logic          start;
  logic          hold;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DB-1:0] mem_data;
  logic [DB-1:0] pix_out;
  logic          pix_valid;
  logic          conv_valid;
  logic [CW-1:0] out_cnt;
  logic          busy;
  logic          done;
  logic          err;

  logic [DB-1:0] mem [NPIX];

  int total = 0;
  int bad   = 0;

  int seq_err, pix_err, pix_cnt, done_cnt, busy_cnt;
  int done_cyc, err_cyc, last_read_cyc, first_read_cyc, final_cyc;
  logic [CW-1:0] cnt_end;
  logic          busy_end, err_end;
  bit            rst_ok;

  conv1_frame_sched #(
    .WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .KERNEL_SIZE(K), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .pix_out(pix_out), .pix_valid(pix_valid), .conv_valid(conv_valid),
    .out_cnt(out_cnt), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous pixel memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  // Drives one frame and scores it against the frame-level rules: reads must be
  // 0..NPIX-1 in order skipping hold cycles, every read delivered once in order.
  task automatic run_frame(input int n_conv, input int hold_at, input int hold_len,
                           input int restart_at, input int rst_at,
                           input bit last_on_entry, input bit rand_hold, input int tail);
    int reads, counted, sent, hold_left, stop;
    bit in_feed, restarted, hold_used, exp_rd, cv;
    logic [DB-1:0] pq[$];
    logic [DB-1:0] exp_pix;
    reads = 0; counted = 0; sent = 0; hold_left = 0; stop = -1;
    in_feed = 0; restarted = 0; hold_used = 0;
    seq_err = 0; pix_err = 0; pix_cnt = 0; done_cnt = 0; busy_cnt = 0;
    done_cyc = -1; err_cyc = -1; last_read_cyc = -1; first_read_cyc = -1;
    final_cyc = -1; rst_ok = 0;
    for (int cyc = 0; cyc < FRAME_LIMIT; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0);
      if (!restarted && in_feed && restart_at >= 0 && reads == restart_at) begin
        start = 1'b1; restarted = 1;
      end
      if (!hold_used && in_feed && hold_at >= 0 && reads == hold_at) begin
        hold_left = hold_len; hold_used = 1;
      end
      hold = (hold_left > 0) || (rand_hold && in_feed && $urandom_range(7) == 0);
      if (hold_left > 0) hold_left--;
      if (rst_at >= 0 && in_feed && reads == rst_at) begin
        rst = 1'b1; #1;
        rst_ok = ({mem_rd_en, mem_addr, pix_out, pix_valid, out_cnt, busy, done, err} === '0);
        start = 0; hold = 0; conv_valid = 0;
        return;
      end
      #1;
      exp_rd = in_feed && !hold;
      if (mem_rd_en !== exp_rd) seq_err++;
      else if (in_feed && mem_addr !== AW'(reads)) seq_err++;
      if (pix_valid === 1'b1) begin
        pix_cnt++;
        if (pq.size() == 0) pix_err++;
        else begin
          exp_pix = pq.pop_front();
          if (pix_out !== exp_pix) pix_err++;
        end
      end
      if (exp_rd) begin
        pq.push_back(mem[reads]);
        if (reads == 0) first_read_cyc = cyc;
        reads++;
        if (reads == NPIX) begin in_feed = 0; last_read_cyc = cyc; end
      end
      if (cyc == 0) in_feed = 1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (cyc >= 1 && err === 1'b1 && err_cyc < 0) err_cyc = cyc;
      cv = 0;
      if (cyc >= 1 && sent < n_conv) begin
        if (last_on_entry && sent == n_conv - 1) cv = exp_rd && (reads == NPIX);
        else cv = ($urandom_range(7) != 0);
      end
      conv_valid = cv;
      if (cv) begin
        sent++;
        if (counted < NOUT) begin
          counted++;
          if (counted == NOUT) final_cyc = cyc;
        end
      end
      if (stop < 0 && (done === 1'b1 || err_cyc >= 0)) stop = cyc + tail;
      if (cyc == stop) break;
    end
    start = 0; hold = 0; conv_valid = 0;
    cnt_end = out_cnt; busy_end = busy; err_end = err;
  endtask

  task automatic test_reset();
    int idle_err;
    rst = 1; start = 0; hold = 0; conv_valid = 0;
    repeat (3) @(posedge clk);
    #1; rst = 0; #1;
    total++;
    if ({mem_rd_en, mem_addr, pix_valid, busy, done, err} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got rd=%b addr=%0d pv=%b busy=%b done=%b err=%b want all 0",
                      mem_rd_en, mem_addr, pix_valid, busy, done, err);
    end
    total++;
    if (out_cnt !== '0 || pix_out !== '0) begin
      bad++; $display("FAIL reset_data: got out_cnt=%0d pix_out=%0h want 0", out_cnt, pix_out);
    end
    idle_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      conv_valid = $urandom_range(1);
      hold = $urandom_range(1);
      #1;
      if (mem_rd_en !== 1'b0 || busy !== 1'b0 || out_cnt !== '0 || done !== 1'b0) idle_err++;
    end
    conv_valid = 0; hold = 0;
    total++;
    if (idle_err !== 0) begin
      bad++; $display("FAIL idle_ignore: got %0d bad idle cycles want 0", idle_err);
    end
  endtask

  task automatic test_full_frame();
    int exp_done;
    run_frame(NOUT, -1, 0, -1, -1, 0, 0, 4);
    exp_done = ((last_read_cyc > final_cyc) ? last_read_cyc : final_cyc) + 2;
    total++;
    if (first_read_cyc !== 1) begin
      bad++; $display("FAIL full_latency: got first read cycle %0d want 1", first_read_cyc);
    end
    total++;
    if (seq_err !== 0) begin bad++; $display("FAIL full_seq: got %0d addr errors want 0", seq_err); end
    total++;
    if (pix_err !== 0 || pix_cnt !== NPIX) begin
      bad++; $display("FAIL full_pix: got err=%0d cnt=%0d want 0/%0d", pix_err, pix_cnt, NPIX);
    end
    total++;
    if (done_cnt !== 1 || done_cyc !== exp_done) begin
      bad++; $display("FAIL full_done: got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cyc, exp_done);
    end
    total++;
    if (busy_cnt !== exp_done) begin
      bad++; $display("FAIL full_busy: got %0d busy cycles want %0d", busy_cnt, exp_done);
    end
    total++;
    if (cnt_end !== CW'(NOUT) || busy_end !== 1'b0 || err_end !== 1'b0) begin
      bad++; $display("FAIL full_end: got out_cnt=%0d busy=%b err=%b want %0d/0/0",
                      cnt_end, busy_end, err_end, NOUT);
    end
  endtask

  task automatic test_hold();
    run_frame(NOUT, 100, 10, -1, -1, 0, 0, 2);
    total++;
    if (seq_err !== 0) begin bad++; $display("FAIL hold_seq: got %0d addr errors want 0", seq_err); end
    total++;
    if (pix_err !== 0 || pix_cnt !== NPIX) begin
      bad++; $display("FAIL hold_pix: got err=%0d cnt=%0d want 0/%0d", pix_err, pix_cnt, NPIX);
    end
    total++;
    if (last_read_cyc !== NPIX + 10) begin
      bad++; $display("FAIL hold_len: got last read cycle %0d want %0d", last_read_cyc, NPIX + 10);
    end
  endtask

  task automatic test_restart_ignored();
    run_frame(NOUT, -1, 0, 300, -1, 0, 1, 6);
    total++;
    if (seq_err !== 0 || pix_err !== 0) begin
      bad++; $display("FAIL restart_seq: got seq=%0d pix=%0d want 0/0", seq_err, pix_err);
    end
    total++;
    if (done_cnt !== 1 || cnt_end !== CW'(NOUT)) begin
      bad++; $display("FAIL restart_done: got done=%0d out_cnt=%0d want 1/%0d", done_cnt, cnt_end, NOUT);
    end
  endtask

  task automatic test_reset_mid();
    run_frame(NOUT, -1, 0, -1, 500, 0, 0, 0);
    total++;
    if (!rst_ok) begin bad++; $display("FAIL rst_mid_outputs: got nonzero outputs want all 0"); end
    repeat (2) @(posedge clk);
    #1; rst = 0;
    @(posedge clk); #2;
    total++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || out_cnt !== '0) begin
      bad++; $display("FAIL rst_mid_release: got pv=%b busy=%b out_cnt=%0d want 0/0/0",
                      pix_valid, busy, out_cnt);
    end
    run_frame(NOUT, -1, 0, -1, -1, 0, 1, 2);
    total++;
    if (first_read_cyc !== 1 || seq_err !== 0 || pix_err !== 0) begin
      bad++; $display("FAIL rst_mid_restart: got first=%0d seq=%0d pix=%0d want 1/0/0",
                      first_read_cyc, seq_err, pix_err);
    end
    total++;
    if (done_cnt !== 1 || cnt_end !== CW'(NOUT)) begin
      bad++; $display("FAIL rst_mid_done: got done=%0d out_cnt=%0d want 1/%0d", done_cnt, cnt_end, NOUT);
    end
  endtask

  task automatic test_saturate();
    run_frame(600, -1, 0, -1, -1, 0, 1, 3);
    total++;
    if (cnt_end !== CW'(NOUT) || done_cnt !== 1) begin
      bad++; $display("FAIL saturate: got out_cnt=%0d done=%0d want %0d/1", cnt_end, done_cnt, NOUT);
    end
  endtask

  task automatic test_last_on_entry();
    run_frame(NOUT, -1, 0, -1, -1, 1, 0, 2);
    total++;
    if (final_cyc !== last_read_cyc || done_cyc !== last_read_cyc + 2 || done_cnt !== 1) begin
      bad++; $display("FAIL drain_entry_done: got cyc=%0d cnt=%0d want %0d/1",
                      done_cyc, done_cnt, last_read_cyc + 2);
    end
  endtask

  task automatic test_timeout();
    run_frame(NOUT - 1, -1, 0, -1, -1, 0, 0, 3);
`ifdef CONV1_SCHED_TIMEOUT_EN
    total++;
    if (err_cyc !== last_read_cyc + TO + 1 || err_end !== 1'b1) begin
      bad++; $display("FAIL timeout_err: got cyc=%0d err=%b want %0d/1", err_cyc, err_end,
                      last_read_cyc + TO + 1);
    end
    total++;
    if (done_cnt !== 0 || busy_end !== 1'b0 || busy_cnt !== last_read_cyc + TO) begin
      bad++; $display("FAIL timeout_state: got done=%0d busy=%b busy_cycles=%0d want 0/0/%0d",
                      done_cnt, busy_end, busy_cnt, last_read_cyc + TO);
    end
`else
    total++;
    if (busy_end !== 1'b1 || done_cnt !== 0 || err_end !== 1'b0) begin
      bad++; $display("FAIL drain_wait: got busy=%b done=%0d err=%b want 1/0/0", busy_end, done_cnt, err_end);
    end
    #1; rst = 1;
    repeat (2) @(posedge clk);
    #1; rst = 0;
`endif
    run_frame(NOUT, -1, 0, -1, -1, 0, 0, 2);
    total++;
    if (done_cnt !== 1 || err_end !== 1'b0 || seq_err !== 0) begin
      bad++; $display("FAIL timeout_recover: got done=%0d err=%b seq=%0d want 1/0/0", done_cnt, err_end, seq_err);
    end
  endtask

  initial begin
    rst = 1; start = 0; hold = 0; conv_valid = 0;
    for (int i = 0; i < NPIX; i++) mem[i] = DB'($urandom);
    test_reset();
    test_full_frame();
    test_hold();
    test_restart_ignored();
    test_reset_mid();
    test_saturate();
    test_last_on_entry();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv1_frame_sched.md
CONV1_FRAME_SCHED -- requirements
Module: conv1_frame_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 28, image columns.
REQ-002 The block SHALL have parameter HEIGHT, default 28, image rows.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, pixel width.
REQ-004 The block SHALL have parameter KERNEL_SIZE, default 5, conv kernel edge.
REQ-005 The block SHALL have parameter TIMEOUT, default 4096, drain watchdog limit in cycles.
REQ-006 Derived constants SHALL be NPIX = WIDTH*HEIGHT, NOUT = (WIDTH-KERNEL_SIZE+1)*(HEIGHT-KERNEL_SIZE+1), AW = $clog2(NPIX).
REQ-007 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port start, input, 1, one-cycle frame request.
REQ-010 The block SHALL have port hold, input, 1, downstream stall; suspends new pixel reads.
REQ-011 The block SHALL have port mem_rd_en, output, 1, pixel memory read strobe.
REQ-012 The block SHALL have port mem_addr, output, AW, pixel memory address.
REQ-013 The block SHALL have port mem_data, input, DATA_BITS, read data, valid one cycle after mem_rd_en.
REQ-014 The block SHALL have port pix_out, output, DATA_BITS, pixel to conv1 layer data_in.
REQ-015 The block SHALL have port pix_valid, output, 1, pix_out qualifier.
REQ-016 The block SHALL have port conv_valid, input, 1, valid_out_conv from conv1 layer.
REQ-017 The block SHALL have port out_cnt, output, $clog2(NOUT+1), conv results counted this frame.
REQ-018 The block SHALL have port busy, output, 1, high in any state except IDLE.
REQ-019 The block SHALL have port done, output, 1, one-cycle frame-complete pulse.
REQ-020 The block SHALL have port err, output, 1, sticky watchdog flag (feature-dependent).

Function
REQ-021 The FSM SHALL have states IDLE, FEED, DRAIN, DONE.
REQ-022 In IDLE, start=1 SHALL move to FEED next cycle, clear out_cnt and the read address to 0, and clear err.
REQ-023 start SHALL be ignored in any state other than IDLE.
REQ-024 In FEED with hold=0, mem_rd_en SHALL be 1 with mem_addr = current address, and the address SHALL increment by 1.
REQ-025 In FEED with hold=1, mem_rd_en SHALL be 0 and the address SHALL be unchanged.
REQ-026 pix_valid SHALL equal mem_rd_en delayed one cycle, and pix_out SHALL be mem_data registered in that cycle; a read issued before hold rises SHALL still be delivered.
REQ-027 When the read at address NPIX-1 is issued, the FSM SHALL go to DRAIN; the address SHALL NOT wrap and no further reads SHALL issue.
REQ-028 conv_valid SHALL increment out_cnt in FEED and DRAIN; out_cnt SHALL saturate at NOUT, and conv_valid SHALL be ignored in IDLE and DONE.
REQ-029 In DRAIN, the FSM SHALL go to DONE on the cycle after out_cnt reaches NOUT, including the case where the final conv_valid coincides with DRAIN entry.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE; out_cnt SHALL hold its final value until the next start.
REQ-031 Latency SHALL be exactly 1 cycle from start to the first mem_rd_en and exactly 1 cycle from mem_rd_en to pix_valid.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, address 0, and mem_rd_en, mem_addr, pix_out, pix_valid, out_cnt, busy, done, err all 0, including mid-frame; no pending read SHALL be delivered after release.

Configuration
REQ-033 With macro CONV1_SCHED_TIMEOUT_EN defined, a cycle counter SHALL run in DRAIN; on reaching TIMEOUT cycles without out_cnt==NOUT, the block SHALL set err=1, skip DONE (done stays 0), and return to IDLE.
REQ-034 Without CONV1_SCHED_TIMEOUT_EN, err SHALL be tied 0 and DRAIN SHALL wait indefinitely.

Verification
REQ-035 Reset, then start pulse, hold=0, conv_valid model of 576 pulses -> 784 consecutive reads on addr 0..783, pix_valid 784 cycles, out_cnt=576, one done pulse, busy low after.
REQ-036 hold=1 for 10 cycles at addr 100 -> mem_rd_en low 10 cycles, addr stays 100, read at addr 99 still delivered; no pixel lost or duplicated.
REQ-037 start pulsed again during FEED at addr 300 -> ignored; addresses continue contiguously, single done.
REQ-038 rst asserted at addr 500 -> all outputs 0 immediately; new start restarts at addr 0, out_cnt 0.
REQ-039 With CONV1_SCHED_TIMEOUT_EN, TIMEOUT=64, only 575 conv_valid pulses -> err=1 64 cycles after DRAIN entry, done never asserted, busy low; without the macro, busy stays high.
REQ-040 600 conv_valid pulses in one frame -> out_cnt saturates at 576, one done pulse.
